// File: rtl/surf6_bringup_sequencer.sv
// SURF-side TURFIO link bringup sequencer.
// Walks the clock chip through reset, programming and enable, then requests
// RXCLK alignment, eye centering and drive training, and finally waits for the
// link to report mode1. Losing RACKCLK drops straight back to IDLE with DOUT
// held low. A step that overruns its time budget lands in ERROR, which holds
// off for a while and then retries from IDLE.
module surf6_bringup_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned TIMEOUT       = 1048576,
  parameter int unsigned HOLDOFF       = 4096
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       rackclk_ok_i,
  input  logic       mode1_ready_i,
  input  logic       prog_done_i,
  input  logic       align_done_i,
  input  logic       align_err_i,
  input  logic       eye_done_i,
  output logic       clk_rst_o,
  output logic       prog_req_o,
  output logic       clk_en_o,
  output logic       align_req_o,
  output logic       eye_req_o,
  output logic       train_o,
  output logic       dout_force_low_o,
  output logic [2:0] state_o,
  output logic [7:0] err_cnt_o
);

  // One step counter serves every timed state, so it must hold the largest limit.
  localparam int unsigned MAX_RS  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_TH  = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int unsigned MAX_ALL = (MAX_RS > MAX_TH) ? MAX_RS : MAX_TH;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF - 1);

  // Low three bits of each code are what state_o reports; ERROR sits above them.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CRST   = 4'd1,
    ST_PROG   = 4'd2,
    ST_SETTLE = 4'd3,
    ST_ALIGN  = 4'd4,
    ST_EYE    = 4'd5,
    ST_TRAIN  = 4'd6,
    ST_RUN    = 4'd7,
    ST_ERROR  = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             rk_meta_q, rk_sync_q;
  logic             rk;
  logic             timed_out;
  logic [3:0]       state_bits_d;

  logic clk_rst_q, clk_rst_d;
  logic prog_req_q, prog_req_d;
  logic clk_en_q, clk_en_d;
  logic align_req_q, align_req_d;
  logic eye_req_q, eye_req_d;
  logic train_q, train_d;
  logic force_low_q, force_low_d;
  logic [2:0] state_out_q, state_out_d;

  // Two-flop synchronizer for the asynchronous RACKCLK-present flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rk_meta_q <= 1'b0;
      rk_sync_q <= 1'b0;
    end else begin
      rk_meta_q <= rackclk_ok_i;
      rk_sync_q <= rk_meta_q;
    end
  end

  assign rk        = rk_sync_q;
  assign timed_out = (cnt_q == TIMEOUT_LAST);

  // Next-state, step counter and error counter logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (rk) state_d = ST_CRST;
      end
      ST_CRST: begin
        if (cnt_q == RST_LAST) state_d = ST_PROG;
      end
      ST_PROG: begin
        // A completion seen on the final budgeted cycle still counts as success.
        if (prog_done_i)    state_d = ST_SETTLE;
        else if (timed_out) state_d = ST_ERROR;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        // A reported alignment failure outranks a simultaneous done.
        if (align_err_i)       state_d = ST_ERROR;
        else if (align_done_i) state_d = ST_EYE;
        else if (timed_out)    state_d = ST_ERROR;
      end
      ST_EYE: begin
        if (eye_done_i)     state_d = ST_TRAIN;
        else if (timed_out) state_d = ST_ERROR;
      end
      ST_TRAIN: begin
        if (mode1_ready_i)  state_d = ST_RUN;
        else if (timed_out) state_d = ST_ERROR;
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!mode1_ready_i) state_d = ST_TRAIN;
      end
      ST_ERROR: begin
        if (cnt_q == HOLDOFF_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing RACKCLK beats every other transition, ERROR included.
    if (!rk) state_d = ST_IDLE;

    // Every state begins its step count from zero.
    if ((state_d != state_q) || !rk) cnt_d = '0;

    if ((state_d == ST_ERROR) && (state_q != ST_ERROR) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  // Output decode from the upcoming state, so registered outputs track state_q.
  always_comb begin
    clk_rst_d    = 1'b0;
    prog_req_d   = 1'b0;
    clk_en_d     = 1'b0;
    align_req_d  = 1'b0;
    eye_req_d    = 1'b0;
    train_d      = 1'b0;
    force_low_d  = 1'b1;
    state_bits_d = state_d;
    state_out_d  = state_bits_d[2:0];

    unique case (state_d)
      ST_IDLE:   ;
      ST_CRST:   clk_rst_d = 1'b1;
      ST_PROG:   prog_req_d = 1'b1;
      ST_SETTLE: clk_en_d = 1'b1;
      ST_ALIGN: begin
        clk_en_d    = 1'b1;
        align_req_d = 1'b1;
      end
      ST_EYE: begin
        clk_en_d  = 1'b1;
        eye_req_d = 1'b1;
      end
      ST_TRAIN: begin
        clk_en_d    = 1'b1;
        train_d     = 1'b1;
        force_low_d = 1'b0;
      end
      ST_RUN: begin
        clk_en_d    = 1'b1;
        force_low_d = 1'b0;
      end
      ST_ERROR:  state_out_d = 3'd7;
      default:   ;
    endcase
  end

  // State, counters and registered output copies.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_cnt_q   <= 8'd0;
      clk_rst_q   <= 1'b0;
      prog_req_q  <= 1'b0;
      clk_en_q    <= 1'b0;
      align_req_q <= 1'b0;
      eye_req_q   <= 1'b0;
      train_q     <= 1'b0;
      force_low_q <= 1'b1;
      state_out_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      clk_rst_q   <= clk_rst_d;
      prog_req_q  <= prog_req_d;
      clk_en_q    <= clk_en_d;
      align_req_q <= align_req_d;
      eye_req_q   <= eye_req_d;
      train_q     <= train_d;
      force_low_q <= force_low_d;
      state_out_q <= state_out_d;
    end
  end

  assign clk_rst_o        = clk_rst_q;
  assign prog_req_o       = prog_req_q;
  assign clk_en_o         = clk_en_q;
  assign align_req_o      = align_req_q;
  assign eye_req_o        = eye_req_q;
  assign train_o          = train_q;
  assign dout_force_low_o = force_low_q;
  assign state_o          = state_out_q;
  assign err_cnt_o        = err_cnt_q;

endmodule
